// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled start/data/parity/stop framing feeding a circular receive FIFO.
// Each FIFO entry is {ferr, perr, data}; errored frames are still stored with their flags.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rxd_i,
    output logic [DATA_BITS-1:0]          rx_data_o,
    output logic                          rx_perr_o,
    output logic                          rx_ferr_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
    output logic                          overrun_o,
    output logic                          busy_o
);

    localparam int unsigned DivRaw = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned TW     = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned PW     = $clog2(OVERSAMPLE);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned EW     = DATA_BITS + 2;

    localparam logic [TW-1:0] TickLast = TW'(Div - 1);
    localparam logic [PW-1:0] PhLast   = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PhMid    = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    BitLast  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    state_e               state_q;
    logic [1:0]           sync_q;
    logic [TW-1:0]        tick_q;
    logic [PW-1:0]        phase_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 push_q;
    logic                 rxs;
    logic                 tick;
    logic                 start_edge;

    assign rxs        = sync_q[1];
    assign tick       = (tick_q == TickLast);
    assign start_edge = (state_q == StIdle) && !rxs;
    assign busy_o     = (state_q != StIdle);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end

    // Restarting the divider on the detected edge centres every later sample in its bit.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_edge || tick) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        state_q <= StStart;
                        phase_q <= '0;
                        perr_q  <= 1'b0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (phase_q == PhMid) begin
                            phase_q <= '0;
                            bit_q   <= '0;
                            state_q <= rxs ? StIdle : StData;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        phase_q <= phase_q + PW'(1);
                        if (phase_q == PhLast) begin
                            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                            if (bit_q == BitLast) begin
                                state_q <= (PARITY != 0) ? StPar : StStop;
                            end else begin
                                bit_q <= bit_q + 4'd1;
                            end
                        end
                    end
                end
                StPar: begin
                    if (tick) begin
                        phase_q <= phase_q + PW'(1);
                        if (phase_q == PhLast) begin
                            perr_q  <= rxs ^ (^shift_q) ^ (PARITY == 2);
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        phase_q <= phase_q + PW'(1);
                        if (phase_q == PhLast) begin
                            ferr_q  <= ~rxs;
                            push_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic          overrun_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic [EW-1:0] head;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && rx_ready_i;
    assign push_ok = push_q && (!full || pop);
    assign head    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= {ferr_q, perr_q, shift_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push_q && full && !pop;
            if (push_ok) begin
                wr_q <= wr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_q <= rd_q + (AW + 1)'(1);
            end
        end
    end

    // Head fields are masked while empty so stale or unwritten storage never leaks out.
    assign rx_valid_o = !empty;
    assign rx_data_o  = empty ? '0 : head[DATA_BITS-1:0];
    assign rx_perr_o  = empty ? 1'b0 : head[DATA_BITS];
    assign rx_ferr_o  = empty ? 1'b0 : head[DATA_BITS+1];
    assign rx_count_o = wr_q - rd_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench: serial frames go into two receivers (no parity / even parity)
// and every FIFO observation is compared with a queue-based model of the expected entries.
module tb_uart_rx_fifo;

    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd_a, rxd_b, ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       perr_a, ferr_a, valid_a, ovr_a, busy_a;
    logic       perr_b, ferr_b, valid_b, ovr_b, busy_b;
    logic [2:0] count_a, count_b;

    int checks = 0;
    int errors = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_b = 0;
    int exp_ovr_a = 0;
    int exp_ovr_b = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ(1600), .BAUD(100), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(Depth)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .rxd_i(rxd_a), .rx_data_o(data_a), .rx_perr_o(perr_a),
        .rx_ferr_o(ferr_a), .rx_valid_o(valid_a), .rx_ready_i(ready_a), .rx_count_o(count_a),
        .overrun_o(ovr_a), .busy_o(busy_a)
    );

    uart_rx_fifo #(
        .CLK_FREQ(3200), .BAUD(100), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(Depth)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .rxd_i(rxd_b), .rx_data_o(data_b), .rx_perr_o(perr_b),
        .rx_ferr_o(ferr_b), .rx_valid_o(valid_b), .rx_ready_i(ready_b), .rx_count_o(count_b),
        .overrun_o(ovr_b), .busy_o(busy_b)
    );

    always @(negedge clk) begin
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input int n);
        if (d == 0) rxd_a = v;
        else rxd_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int d, input logic [7:0] data, input bit use_par,
                              input bit pbit, input bit stopb);
        int per;
        per = (d == 0) ? 16 : 32;
        drive(d, 1'b0, per);
        for (int i = 0; i < 8; i++) drive(d, data[i], per);
        if (use_par) drive(d, pbit, per);
        drive(d, stopb, per);
        drive(d, 1'b1, 2 * per);
    endtask

    task automatic expect_frame(input int d, input logic [9:0] e);
        if (d == 0) begin
            if (q_a.size() < Depth) q_a.push_back(e);
            else exp_ovr_a++;
        end else begin
            if (q_b.size() < Depth) q_b.push_back(e);
            else exp_ovr_b++;
        end
    endtask

    task automatic check_state(input int d, input string tag);
        if (d == 0) begin
            check({tag, ".count"}, 32'(count_a), 32'(q_a.size()));
            check({tag, ".valid"}, 32'(valid_a), 32'(q_a.size() != 0));
            if (q_a.size() != 0) check({tag, ".head"}, 32'({ferr_a, perr_a, data_a}), 32'(q_a[0]));
        end else begin
            check({tag, ".count"}, 32'(count_b), 32'(q_b.size()));
            check({tag, ".valid"}, 32'(valid_b), 32'(q_b.size() != 0));
            if (q_b.size() != 0) check({tag, ".head"}, 32'({ferr_b, perr_b, data_b}), 32'(q_b[0]));
        end
    endtask

    task automatic pop(input int d);
        if (d == 0 && q_a.size() != 0) begin
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
            void'(q_a.pop_front());
        end else if (d == 1 && q_b.size() != 0) begin
            ready_b = 1'b1;
            @(negedge clk);
            ready_b = 1'b0;
            void'(q_b.pop_front());
        end
    endtask

    initial begin
        logic [7:0] d8;
        bit         sb;
        bit         pb;
        int         base;

        rst = 1'b1;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        ready_a = 1'b0;
        ready_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.data", 32'(data_a), 32'h0);
        check("rst.perr", 32'(perr_a), 32'h0);
        check("rst.ferr", 32'(ferr_a), 32'h0);
        check("rst.valid", 32'(valid_a), 32'h0);
        check("rst.count", 32'(count_a), 32'h0);
        check("rst.overrun", 32'(ovr_a), 32'h0);
        check("rst.busy", 32'(busy_a), 32'h0);
        check("rst.busy_b", 32'(busy_b), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic frame, then a framing error
        send_frame(0, 8'hA5, 0, 0, 1);
        expect_frame(0, {1'b0, 1'b0, 8'hA5});
        check_state(0, "a5");
        pop(0);
        check_state(0, "a5.pop");
        send_frame(0, 8'h3C, 0, 0, 0);
        expect_frame(0, {1'b1, 1'b0, 8'h3C});
        check_state(0, "ferr");
        check("ferr.busy", 32'(busy_a), 32'h0);
        pop(0);

        // Short glitch is rejected
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 1);
        check("glitch.busy_mid", 32'(busy_a), 32'h1);
        drive(0, 1'b1, 30);
        check("glitch.busy_end", 32'(busy_a), 32'h0);
        check_state(0, "glitch");

        // Overflow with consumer stalled, then drain in order
        base = ovr_cnt_a;
        for (int i = 0; i < 5; i++) begin
            d8 = 8'($urandom);
            send_frame(0, d8, 0, 0, 1);
            expect_frame(0, {2'b00, d8});
        end
        check_state(0, "full");
        check("full.overrun", 32'(ovr_cnt_a - base), 32'(exp_ovr_a));
        for (int i = 0; i < 4; i++) begin
            pop(0);
            check_state(0, "drain");
        end

        // Random frames and random pops, pointers wrap
        for (int i = 0; i < 10; i++) begin
            d8 = 8'($urandom);
            sb = ($urandom_range(3) != 0);
            send_frame(0, d8, 0, 0, sb);
            expect_frame(0, {~sb, 1'b0, d8});
            check_state(0, "rand");
            if ($urandom_range(1) == 1) begin
                pop(0);
                check_state(0, "rand.pop");
            end
        end
        check("rand.overrun", 32'(ovr_cnt_a - base), 32'(exp_ovr_a));

        // Even parity receiver
        send_frame(1, 8'h07, 1, 0, 1);
        expect_frame(1, {1'b0, 1'b1, 8'h07});
        check_state(1, "par0");
        pop(1);
        send_frame(1, 8'h07, 1, 1, 1);
        expect_frame(1, {1'b0, 1'b0, 8'h07});
        check_state(1, "par1");
        pop(1);
        for (int i = 0; i < 5; i++) begin
            d8 = 8'($urandom);
            pb = 1'($urandom_range(1));
            send_frame(1, d8, 1, pb, 1);
            expect_frame(1, {1'b0, 1'(($countones(d8) + int'(pb)) % 2), d8});
            check_state(1, "par.rand");
            pop(1);
        end
        check("par.overrun", 32'(ovr_cnt_b), 32'(exp_ovr_b));

        // Reset in the middle of a frame drops it and the stored data
        if (q_a.size() == 0) begin
            send_frame(0, 8'h81, 0, 0, 1);
            expect_frame(0, {2'b00, 8'h81});
        end
        drive(0, 1'b0, 16);
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 16);
        drive(0, 1'b0, 8);
        rst = 1'b1;
        rxd_a = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        check("midrst.busy", 32'(busy_a), 32'h0);
        check_state(0, "midrst");
        drive(0, 1'b1, 16);
        send_frame(0, 8'h5A, 0, 0, 1);
        expect_frame(0, {2'b00, 8'h5A});
        check_state(0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
